postproc_engine: RTL
====================

Name: postproc_engine

Overview:
- Parametrised successor to the fixed two-lane bias→scale writeback path.
- Processes LANES × 32-bit signed lanes per beat: saturating bias add, then fixed-point scale with round and saturate.
- Per-lane bias/scale are loaded through an addressed config byte stream driven by the existing spi_slave rx_data/rx_valid.
- Full valid/ready backpressure on both sides, with an internal output FIFO.

Parameters:
- LANES, 2, number of 32-bit lanes (1..16).
- SHIFT, 16, fractional bits of the scale (Q(32-SHIFT).SHIFT), 1..30.
- DEPTH, 4, output FIFO entries (power of 2, ≥4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_byte_i  in  8  config byte from spi_slave
- cfg_byte_valid_i  in  1  one-cycle strobe per byte
- cfg_frame_i  in  1  high while SPI chip-select is active
- in_data_i  in  LANES*32  lane l at bits [32l+31:32l], signed
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- out_data_o  out  LANES*32  processed beat
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  downstream accept
- cfg_err_o  out  1  sticky, bad register index
- cfg_busy_o  out  1  parser mid-transaction

Behaviour:
- Reset (async assert, sync deassert by the parent): out_valid_o=0, in_ready_o=0 during reset and 1 on the first cycle after, cfg_err_o=0, cfg_busy_o=0, FIFO empty, all bias=0, all scale=1<<SHIFT (unity).
- Reset mid-operation drops all in-flight and queued beats and any partial config word.
- Config parser FSM:
  - IDLE: first byte is the command. bit7=1 means write; bits[6:0] are the index. Go to DATA with cnt=0. A byte with bit7=0 is ignored and the FSM stays in IDLE.
  - DATA: shift 4 bytes MSB-first. On the 4th byte commit to the register and return to IDLE.
  - Index map: 2l = bias[l], 2l+1 = scale[l], for l<LANES. Any other index: the 4 bytes are consumed and discarded, and cfg_err_o is set. cfg_err_o clears only on reset.
  - cfg_frame_i low while in DATA: abort to IDLE, partial word discarded, no commit, no error.
  - cfg_busy_o=1 in DATA.
  - A committed value is used by beats entering stage 1 on the cycle after the 4th byte. Beats already in flight keep the values they captured.
- Datapath, per lane, 2 pipeline stages:
  - S1: b = sat32(d + bias), using a 33-bit sum.
  - S2: p = b*scale (64-bit signed); r = (p + (1<<(SHIFT-1))) >>> SHIFT (arithmetic shift); out = sat32(r).
  - sat32 clamps to [-2^31, 2^31-1].
- Latency: an accepted beat is visible at out_valid_o 3 cycles after acceptance when the FIFO is empty (2 stages + FIFO write).
- Flow control: credit-based. in_ready_o = (fifo_count + v_s1 + v_s2) < DEPTH. Pipeline stages never stall.
- FIFO: full/empty via count. Simultaneous push and pop when full is legal and only occurs with a credit-reserved slot. Pop when empty is impossible (out_valid_o=0). Pointers wrap modulo DEPTH.
- Ordering is strict FIFO; no beat is ever dropped or duplicated.

Optional Feature:
- POSTPROC_RELU_EN defined:
  - Index 0x7E is a LANES-bit ReLU mask register (low LANES bits of the 32-bit word; reset 0).
  - In S2, lanes with their mask bit set output max(out,0) after saturation.
- Undefined: no ReLU logic, and index 0x7E is out-of-range (sets cfg_err_o).

Decomposition:
- Package postproc_pkg holds:
  - LANE_W=32 and the command-bit and index constants (CMD_WR bit 7, IDX_RELU 7'h7E).
  - Parser state enum typedef (IDLE, DATA).
  - sat32 and round-shift functions.
- Sub-module postproc_lane (one lane's S1/S2 registers and arithmetic) is instantiated LANES times via generate. The parser, credit logic and FIFO stay in the top.

Test Plan:
- Defaults after reset, LANES=2, in lane0=100, lane1=-7 → out {-7,100}, exactly 3 cycles after acceptance.
- Config write 0x80,00,00,00,05 (bias0=5) and 0x81,00,02,00,00 (scale0=2.0); input lane0=10 → out lane0=30. Also input lane0=1, scale0=0x00008000 → 0.5 rounds to 1.
- Saturation: bias0=1, input lane0=0x7FFFFFFF → 0x7FFFFFFF. Scale0=4.0, input lane0=-2^30 → 0x80000000.
- Backpressure: out_ready_i=0 with continuous valid input → exactly DEPTH beats accepted, then in_ready_o=0. Release → all DEPTH beats out, in order.
- Config abort and error: write 0x80,AA then cfg_frame_i low → bias0 unchanged, cfg_err_o=0. Write 0x85,x,x,x,x with LANES=2 → cfg_err_o=1, no register changed.
- Async reset asserted with 3 beats queued → out_valid_o=0 immediately, and the next output after reset reflects reset bias/scale.

Source files
------------

// File: rtl/postproc_pkg.sv
// postproc_pkg: shared constants, parser state type and arithmetic helpers
// for the postproc_engine block (lane width, config command/index encoding,
// 32-bit saturation and round-to-nearest arithmetic shift).
package postproc_pkg;

  localparam int LANE_W = 32;

  // Config command byte: bit 7 marks a write, bits [6:0] carry the index.
  localparam int           CMD_WR   = 7;
  localparam logic [6:0]   IDX_RELU = 7'h7E;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } parser_state_e;

  localparam logic signed [65:0] SAT_MAX = 66'sd2147483647;
  localparam logic signed [65:0] SAT_MIN = -66'sd2147483648;

  // Clamp a wide signed value into the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [65:0] v);
    if (v > SAT_MAX)
      return 32'h7FFF_FFFF;
    else if (v < SAT_MIN)
      return 32'h8000_0000;
    else
      return v[31:0];
  endfunction

  // Round half up, then arithmetic shift right. Two guard bits keep the
  // rounding add from overflowing for any 64-bit product.
  function automatic logic signed [65:0] round_shift(input logic signed [63:0] p,
                                                     input int shift);
    logic signed [65:0] t;
    t = {{2{p[63]}}, p};
    t = t + (66'sd1 <<< (shift - 1));
    return t >>> shift;
  endfunction

endpackage

// File: rtl/postproc_lane.sv
// postproc_lane: one 32-bit signed lane of the two-stage datapath.
//   S1: b = sat32(d + bias); the scale (and ReLU bit) are captured alongside
//       so an in-flight beat keeps the config it entered with.
//   S2: res = sat32(round(b * scale) >>> SHIFT), optionally clamped at 0.
// Ports: clk, rst_n, load (beat enters S1), d, bias, scale,
//        relu (only with POSTPROC_RELU_EN), res (S2 result register).
// Build option: POSTPROC_RELU_EN adds the per-lane ReLU clamp.
module postproc_lane
  import postproc_pkg::*;
#(
  parameter int SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  input  logic [31:0] bias,
  input  logic [31:0] scale,
`ifdef POSTPROC_RELU_EN
  input  logic        relu,
`endif
  output logic [31:0] res
);

  logic [31:0]        b_q;
  logic [31:0]        scale_q;
  logic [32:0]        sum;
  logic signed [63:0] prod;
  logic [31:0]        s2_val;

  assign sum  = {d[31], d} + {bias[31], bias};
  assign prod = 64'($signed(b_q)) * 64'($signed(scale_q));

`ifdef POSTPROC_RELU_EN
  logic relu_q;
  logic [31:0] sat_val;
  assign sat_val = sat32(round_shift(prod, SHIFT));
  assign s2_val  = (relu_q && sat_val[31]) ? 32'd0 : sat_val;
`else
  assign s2_val  = sat32(round_shift(prod, SHIFT));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      scale_q <= '0;
`ifdef POSTPROC_RELU_EN
      relu_q  <= 1'b0;
`endif
    end else if (load) begin
      b_q     <= sat32({{33{sum[32]}}, sum});
      scale_q <= scale;
`ifdef POSTPROC_RELU_EN
      relu_q  <= relu;
`endif
    end
  end

  // S2 always advances; the top tracks which cycles carry a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res <= '0;
    else        res <= s2_val;
  end

endmodule

// File: rtl/postproc_engine.sv
// postproc_engine: LANES x 32-bit bias -> scale post-processing path.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_byte_i/_valid_i/_frame_i  config byte stream from spi_slave
//   in_data_i/_valid_i/_ready_o   input beats (lane l at [32l+31:32l])
//   out_data_o/_valid_o/_ready_i  output beats from the internal FIFO
//   cfg_err_o                  sticky: write to an unmapped index
//   cfg_busy_o                 parser is collecting data bytes
// Handshake: a beat transfers on any cycle where valid && ready are both
// high; valid must hold with stable data until it transfers.
// Config: command byte {1, idx[6:0]} then 4 data bytes MSB-first.
// Index 2l = bias[l], 2l+1 = scale[l]. Frame drop mid-word aborts silently.
// Build option: POSTPROC_RELU_EN maps index 0x7E to a per-lane ReLU mask.
module postproc_engine
  import postproc_pkg::*;
#(
  parameter int LANES = 2,
  parameter int SHIFT = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_byte_i,
  input  logic                  cfg_byte_valid_i,
  input  logic                  cfg_frame_i,
  input  logic [LANES*32-1:0]   in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [LANES*32-1:0]   out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  cfg_err_o,
  output logic                  cfg_busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SCALE_ONE = 32'(64'd1 << SHIFT);

  // ---------------- config parser ----------------
  parser_state_e state, state_n;
  logic [1:0]    cnt;
  logic [6:0]    idx;
  logic [23:0]   shreg;
  logic          commit;
  logic [31:0]   word;

  logic [31:0]   bias  [LANES];
  logic [31:0]   scale [LANES];

  assign commit     = (state == ST_DATA) && cfg_frame_i && cfg_byte_valid_i && (cnt == 2'd3);
  assign word       = {shreg, cfg_byte_i};
  assign cfg_busy_o = (state == ST_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (cfg_byte_valid_i && cfg_byte_i[CMD_WR]) state_n = ST_DATA;
      ST_DATA: begin
        if (!cfg_frame_i)                           state_n = ST_IDLE;
        else if (cfg_byte_valid_i && cnt == 2'd3)   state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= '0;
      if (cfg_byte_valid_i && cfg_byte_i[CMD_WR]) idx <= cfg_byte_i[6:0];
    end else if (cfg_frame_i && cfg_byte_valid_i) begin
      cnt   <= cnt + 2'd1;
      shreg <= {shreg[15:0], cfg_byte_i};
    end
  end

`ifdef POSTPROC_RELU_EN
  logic [LANES-1:0] relu_mask;
  logic             hit_relu;
  assign hit_relu = (idx == IDX_RELU);
`else
  logic             hit_relu;
  assign hit_relu = 1'b0;
`endif

  logic hit_lane;
  assign hit_lane = (idx < 7'(2 * LANES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        bias[l]  <= '0;
        scale[l] <= SCALE_ONE;
      end
      cfg_err_o <= 1'b0;
`ifdef POSTPROC_RELU_EN
      relu_mask <= '0;
`endif
    end else if (commit) begin
      for (int l = 0; l < LANES; l++) begin
        if (idx == 7'(2 * l))     bias[l]  <= word;
        if (idx == 7'(2 * l + 1)) scale[l] <= word;
      end
`ifdef POSTPROC_RELU_EN
      if (hit_relu) relu_mask <= word[LANES-1:0];
`endif
      if (!hit_lane && !hit_relu) cfg_err_o <= 1'b1;
    end
  end

  // ---------------- datapath ----------------
  logic                  accept;
  logic                  v_s1, v_s2;
  logic [LANES*32-1:0]   s2_data;

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s1 <= 1'b0;
      v_s2 <= 1'b0;
    end else begin
      v_s1 <= accept;
      v_s2 <= v_s1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    postproc_lane #(.SHIFT(SHIFT)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .d     (in_data_i[32*l +: 32]),
      .bias  (bias[l]),
      .scale (scale[l]),
`ifdef POSTPROC_RELU_EN
      .relu  (relu_mask[l]),
`endif
      .res   (s2_data[32*l +: 32])
    );
  end

  // ---------------- output FIFO with credit-based admission ----------------
  logic [LANES*32-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [AW+1:0]       credit;
  logic                push, pop;

  assign push        = v_s2;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (count != '0);
  assign out_data_o  = mem[rd_ptr];

  // Beats in S1/S2 already own a FIFO slot, so the pipeline never stalls.
  assign credit     = (AW+2)'(count) + (AW+2)'(v_s1) + (AW+2)'(v_s2);
  assign in_ready_o = rst_n && (credit < (AW+2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
